bsg_idiv_iterative: RTL and testbench
=====================================

# bsg_idiv_iterative

Iterative 32-bit integer divider, signed and unsigned, producing quotient or remainder over one restoring-division step per cycle. It is the inverse-operation companion to the iterative multiplier in the execute stage. It uses the same valid/ready-and request side and valid/yumi result side, so both units plug into the same long-latency issue slot. Area-optimised: one shared (width_p+1)-bit adder/subtractor, no lookahead.

## Interface
- width_p, default 32: operand and result width.
- clk_i  input  1  single clock; all state updates on rising edge.
- reset_n_i  input  1  reset, asynchronous, active-low.
- v_i  input  1  request valid.
- ready_and_o  output  1  divider idle; request accepted when v_i & ready_and_o.
- dividend_i  input  width_p  dividend.
- divisor_i  input  width_p  divisor.
- signed_i  input  1  treat both operands as two's complement.
- gets_remainder_i  input  1  1: return remainder; 0: return quotient.
- v_o  output  1  result valid.
- result_o  output  width_p  quotient or remainder.
- yumi_i  input  1  consumer takes the result; legal only while v_o = 1.

## Operation
- States: IDLE, NEG_A, NEG_B, CALC, NEG_R, DONE. Encoding lives in the shared package.
- IDLE: ready_and_o = 1. On v_i, latch dividend, divisor, signed_i, gets_remainder_i, and the flags neg_a = signed_i & dividend[msb], neg_b = signed_i & divisor[msb], div_zero = (divisor_i == 0). Go to NEG_A.
- NEG_A: if neg_a, dividend_r <= ~dividend_r + 1 via the shared adder. Go to NEG_B.
- NEG_B: if neg_b, divisor_r <= ~divisor_r + 1. Clear rem_r (width_p+1 bits). Clear the step counter. Go to CALC.
- CALC, one step per cycle, width_p cycles:
  - trial = {rem_r[width_p-1:0], quo_r[msb]} - {1'b0, divisor_r}.
  - If trial[width_p] == 0: rem_r <= trial, quo_r <= {quo_r << 1 | 1}.
  - Else: rem_r <= {rem_r[width_p-1:0], quo_r[msb]}, quo_r <= quo_r << 1 (restore).
  - quo_r is initialised with |dividend|.
  - Counter is lg(width_p+1) bits. Exit to NEG_R when the counter reaches width_p-1.
- NEG_R: select quotient or remainder into result_r, and negate when required:
  - Quotient is negated iff neg_a ^ neg_b and !div_zero.
  - Remainder is negated iff neg_a. Remainder sign follows the dividend.
  - Go to DONE.
- DONE: v_o = 1, result_o = result_r. yumi_i returns to IDLE; otherwise hold.
- Divide by zero: quotient = all ones (-1 signed, 2^width_p-1 unsigned). Remainder = original dividend_i. This falls out of the algorithm plus the div_zero negation mask.
- Signed overflow (0x8000_0000 / -1): quotient 0x8000_0000, remainder 0. No trap.
- Unsigned mode: all neg flags are 0; NEG_A, NEG_B and NEG_R still take one cycle each. Latency is constant.

## Timing
- Reset (reset_n_i low, any state, including mid-CALC): state is IDLE immediately, asynchronously. Values:
  - ready_and_o = 1, v_o = 0, result_o = 0.
  - All operand, flag and counter registers are 0.
  - v_i is ignored while reset_n_i is low.
  - First accept is possible on the first rising edge after deassertion.
- Latency: with acceptance on edge E0, v_o rises after edge E0 + width_p + 3 (35 for width_p = 32). This is independent of operands and sign.
- v_o and result_o stay stable from DONE until the edge where yumi_i = 1.
- The cycle after yumi_i, ready_and_o = 1. Back-to-back issue costs one IDLE cycle: there is no accept in DONE.
- ready_and_o and v_o are never both 1.
- Inputs are sampled only on the accept edge. Changes to dividend_i, divisor_i, signed_i and gets_remainder_i afterwards have no effect.

## Structure
- bsg_idiv_pkg holds:
  - the state enum typedef (3-bit);
  - the divide-by-zero quotient constant (all ones, width-parameterised via a function).
- One sub-module: bsg_idiv_addsub, a (width_p+1)-bit adder/subtractor. Inputs are a, b and sub; output is the sum. It is shared by the NEG_A/NEG_B/NEG_R negation (a = ~x, b = 1, add) and the CALC trial subtraction.
- All control logic stays in the top: FSM, step counter, flag registers, and the result mux with negation select.

## Test plan
- Unsigned 100 / 7, quotient request: v_o after 35 cycles, result_o = 14. Repeat with gets_remainder_i = 1: result_o = 2.
- Signed -100 / 7: quotient 0xFFFF_FFF2, remainder 0xFFFF_FFFE. Signed 100 / -7: quotient 0xFFFF_FFF2, remainder 2.
- Divide by zero:
  - signed 0xFFFF_FF9C / 0: quotient 0xFFFF_FFFF, remainder 0xFFFF_FF9C;
  - unsigned 5 / 0: quotient 0xFFFF_FFFF, remainder 5.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: quotient 0x8000_0000, remainder 0. Unsigned same operands: quotient 0, remainder 0x8000_0000.
- Backpressure: hold yumi_i = 0 for 5 cycles in DONE. v_o and result_o must not change. Pulse yumi_i, then issue a new request on the next IDLE cycle; it is accepted.
- Reset mid-CALC (step 10): drive reset_n_i low between edges. ready_and_o = 1 and v_o = 0 without waiting for a clock. After release, 1000 / 10 returns 100 in 35 cycles.

Source files
------------

// File: rtl/bsg_idiv_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// divide-by-zero quotient constant.
package bsg_idiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NEG_A = 3'd1,
    NEG_B = 3'd2,
    CALC  = 3'd3,
    NEG_R = 3'd4,
    DONE  = 3'd5
  } idiv_state_e;

  localparam int max_width_lp = 64;

  // All-ones pattern of the requested width, right-aligned in a max-width word.
  function automatic logic [max_width_lp-1:0] div_zero_quotient(input int unsigned width);
    logic [max_width_lp-1:0] ones;
    ones = '1;
    return (width >= max_width_lp) ? ones : (ones >> (max_width_lp - width));
  endfunction

endpackage

// File: rtl/bsg_idiv_addsub.sv
// Single shared adder/subtractor used for operand/result negation and the
// restoring-division trial subtraction.
module bsg_idiv_addsub
  import bsg_idiv_pkg::*;
#(
  parameter int width_p = 33
)
(
  input  logic [width_p-1:0] a,
  input  logic [width_p-1:0] b,
  input  logic               sub,
  output logic [width_p-1:0] sum
);

  assign sum = a + (b ^ {width_p{sub}}) + width_p'(sub);

endmodule

// File: rtl/bsg_idiv_iterative.sv
// Iterative signed/unsigned restoring divider, one quotient bit per cycle,
// valid/ready-and request side and valid/yumi result side.
module bsg_idiv_iterative
  import bsg_idiv_pkg::*;
#(
  parameter int width_p = 32
)
(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_and_o,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  input  logic               signed_i,
  input  logic               gets_remainder_i,
  output logic               v_o,
  output logic [width_p-1:0] result_o,
  input  logic               yumi_i
);

  localparam int cnt_w_lp = $clog2(width_p + 1);
  localparam logic [width_p-1:0] div_zero_quo_lp = width_p'(div_zero_quotient(width_p));
  localparam logic [width_p:0]   one_lp          = {{width_p{1'b0}}, 1'b1};

  idiv_state_e state_r, state_n;

  // quo_r starts as the dividend and is shifted into the quotient during CALC.
  logic [width_p-1:0]  quo_r;
  logic [width_p-1:0]  divisor_r;
  logic [width_p:0]    rem_r;
  logic [width_p-1:0]  result_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                neg_a_r;
  logic                neg_b_r;
  logic                div_zero_r;
  logic                gets_rem_r;

  logic [width_p:0]    add_a;
  logic [width_p:0]    add_b;
  logic                add_sub;
  logic [width_p:0]    add_sum;

  logic [width_p:0]    shifted_rem;
  logic [width_p-1:0]  res_sel;
  logic                res_neg;
  logic                accept;
  logic                calc_last;
  logic                unused_rem_msb;

  assign accept      = v_i & (state_r == IDLE);
  assign calc_last   = (cnt_r == cnt_w_lp'(width_p - 1));
  assign shifted_rem = {rem_r[width_p-1:0], quo_r[width_p-1]};

  // The div_zero mask keeps the all-ones quotient from being negated.
  assign res_sel = gets_rem_r ? rem_r[width_p-1:0]
                              : (div_zero_r ? div_zero_quo_lp : quo_r);
  assign res_neg = gets_rem_r ? neg_a_r : ((neg_a_r ^ neg_b_r) & ~div_zero_r);

  // Trial never sets the top remainder bit; it only carries the borrow.
  assign unused_rem_msb = rem_r[width_p];

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    case (state_r)
      NEG_A: begin
        add_a = {1'b0, ~quo_r};
        add_b = one_lp;
      end
      NEG_B: begin
        add_a = {1'b0, ~divisor_r};
        add_b = one_lp;
      end
      CALC: begin
        add_a   = shifted_rem;
        add_b   = {1'b0, divisor_r};
        add_sub = 1'b1;
      end
      NEG_R: begin
        add_a = {1'b0, ~res_sel};
        add_b = one_lp;
      end
      default: ;
    endcase
  end

  bsg_idiv_addsub #(
    .width_p(width_p + 1)
  ) addsub (
    .a  (add_a),
    .b  (add_b),
    .sub(add_sub),
    .sum(add_sum)
  );

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (v_i) state_n = NEG_A;
      NEG_A:   state_n = NEG_B;
      NEG_B:   state_n = CALC;
      CALC:    if (calc_last) state_n = NEG_R;
      NEG_R:   state_n = DONE;
      DONE:    if (yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      quo_r      <= '0;
      divisor_r  <= '0;
      rem_r      <= '0;
      result_r   <= '0;
      cnt_r      <= '0;
      neg_a_r    <= 1'b0;
      neg_b_r    <= 1'b0;
      div_zero_r <= 1'b0;
      gets_rem_r <= 1'b0;
    end else begin
      state_r <= state_n;
      case (state_r)
        IDLE: begin
          if (accept) begin
            quo_r      <= dividend_i;
            divisor_r  <= divisor_i;
            gets_rem_r <= gets_remainder_i;
            neg_a_r    <= signed_i & dividend_i[width_p-1];
            neg_b_r    <= signed_i & divisor_i[width_p-1];
            div_zero_r <= (divisor_i == '0);
          end
        end
        NEG_A: begin
          if (neg_a_r) quo_r <= add_sum[width_p-1:0];
        end
        NEG_B: begin
          if (neg_b_r) divisor_r <= add_sum[width_p-1:0];
          rem_r <= '0;
          cnt_r <= '0;
        end
        CALC: begin
          // Borrow clear means the divisor fits: keep the difference, shift in 1.
          if (!add_sum[width_p]) begin
            rem_r <= add_sum;
            quo_r <= {quo_r[width_p-2:0], 1'b1};
          end else begin
            rem_r <= shifted_rem;
            quo_r <= {quo_r[width_p-2:0], 1'b0};
          end
          cnt_r <= cnt_r + 1'b1;
        end
        NEG_R: begin
          result_r <= res_neg ? add_sum[width_p-1:0] : res_sel;
        end
        default: ;
      endcase
    end
  end

  assign ready_and_o = (state_r == IDLE);
  assign v_o         = (state_r == DONE);
  assign result_o    = result_r;

endmodule

// File: tb/tb_bsg_idiv_iterative.sv
// Self-checking bench for bsg_idiv_iterative: directed vector table, random
// operands against an arithmetic reference, backpressure and async reset.
module tb_bsg_idiv_iterative;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        r;
    logic [31:0] exp;
  } vec_t;

  localparam int expLatency = 35;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_and_o;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        signed_i;
  logic        gets_remainder_i;
  logic        v_o;
  logic [31:0] result_o;
  logic        yumi_i;

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bsg_idiv_iterative #(.width_p(32)) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n_i),
    .v_i             (v_i),
    .ready_and_o     (ready_and_o),
    .dividend_i      (dividend_i),
    .divisor_i       (divisor_i),
    .signed_i        (signed_i),
    .gets_remainder_i(gets_remainder_i),
    .v_o             (v_o),
    .result_o        (result_o),
    .yumi_i          (yumi_i)
  );

  function automatic logic [31:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input logic r);
    longint sa;
    longint sb;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return r ? 32'(sa % sb) : 32'(sa / sb);
    end
    return r ? (a % b) : (a / b);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Issue one request and wait for the result; optionally consume it with yumi.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input logic r, input bit autoYumi,
                               output logic [31:0] res, output int lat);
    int waitCyc;
    waitCyc = 0;
    @(negedge clk);
    while (!ready_and_o && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!ready_and_o) checkOutput("ready timeout", {31'b0, ready_and_o}, 32'd1);
    v_i              = 1'b1;
    dividend_i       = a;
    divisor_i        = b;
    signed_i         = s;
    gets_remainder_i = r;
    @(posedge clk);
    #1;
    v_i              = 1'b0;
    dividend_i       = $urandom;
    divisor_i        = $urandom;
    signed_i         = 1'($urandom_range(0, 1));
    gets_remainder_i = 1'($urandom_range(0, 1));
    lat = 0;
    while (!v_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!v_o) checkOutput("v_o timeout", {31'b0, v_o}, 32'd1);
    checkOutput("ready low in DONE", {31'b0, ready_and_o}, 32'd0);
    res = result_o;
    if (autoYumi) begin
      yumi_i = 1'b1;
      @(posedge clk);
      #1;
      yumi_i = 1'b0;
      checkOutput("ready after yumi", {31'b0, ready_and_o}, 32'd1);
      checkOutput("v_o after yumi", {31'b0, v_o}, 32'd0);
    end
  endtask

  initial begin
    vec_t        vecs[12];
    logic [31:0] res;
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic        rr;
    int          lat;

    vecs[0]  = '{"u 100/7 q",        32'd100,       32'd7,         1'b0, 1'b0, 32'd14};
    vecs[1]  = '{"u 100/7 r",        32'd100,       32'd7,         1'b0, 1'b1, 32'd2};
    vecs[2]  = '{"s -100/7 q",       32'hFFFF_FF9C, 32'd7,         1'b1, 1'b0, 32'hFFFF_FFF2};
    vecs[3]  = '{"s -100/7 r",       32'hFFFF_FF9C, 32'd7,         1'b1, 1'b1, 32'hFFFF_FFFE};
    vecs[4]  = '{"s 100/-7 q",       32'd100,       32'hFFFF_FFF9, 1'b1, 1'b0, 32'hFFFF_FFF2};
    vecs[5]  = '{"s 100/-7 r",       32'd100,       32'hFFFF_FFF9, 1'b1, 1'b1, 32'd2};
    vecs[6]  = '{"s div0 q",         32'hFFFF_FF9C, 32'd0,         1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[7]  = '{"s div0 r",         32'hFFFF_FF9C, 32'd0,         1'b1, 1'b1, 32'hFFFF_FF9C};
    vecs[8]  = '{"u 5/0 q",          32'd5,         32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[9]  = '{"u 5/0 r",          32'd5,         32'd0,         1'b0, 1'b1, 32'd5};
    vecs[10] = '{"s overflow q",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000};
    vecs[11] = '{"u min/allones r",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000};

    reset_n_i        = 1'b0;
    v_i              = 1'b1;
    yumi_i           = 1'b0;
    dividend_i       = 32'd9;
    divisor_i        = 32'd3;
    signed_i         = 1'b0;
    gets_remainder_i = 1'b0;
    #17;
    checkOutput("reset ready", {31'b0, ready_and_o}, 32'd1);
    checkOutput("reset v_o", {31'b0, v_o}, 32'd0);
    checkOutput("reset result", result_o, 32'd0);
    v_i       = 1'b0;
    reset_n_i = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, 1'b1, res, lat);
      checkOutput(vecs[i].name, res, vecs[i].exp);
      checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(expLatency));
    end

    checkOutput("u overflow q model", refModel(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0), 32'd0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, res, lat);
    checkOutput("s overflow r", res, 32'd0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, res, lat);
    checkOutput("u overflow q", res, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(1, 20));
        1:       rb = 32'd0 - 32'($urandom_range(1, 20));
        2:       rb = (i % 8 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rs, rr, 1'b1, res, lat);
      checkOutput($sformatf("rand %h/%h s%0d r%0d", ra, rb, rs, rr), res, refModel(ra, rb, rs, rr));
      checkOutput("rand latency", 32'(lat), 32'(expLatency));
    end

    // Backpressure: result must hold while yumi stays low.
    applyStimulus(32'd1234, 32'd11, 1'b0, 1'b0, 1'b0, held, lat);
    checkOutput("bp result", held, 32'd112);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp v_o hold", {31'b0, v_o}, 32'd1);
      checkOutput("bp result hold", result_o, held);
    end
    yumi_i = 1'b1;
    @(posedge clk);
    #1;
    yumi_i = 1'b0;
    checkOutput("bp ready after yumi", {31'b0, ready_and_o}, 32'd1);
    applyStimulus(32'd77, 32'd5, 1'b0, 1'b1, 1'b1, res, lat);
    checkOutput("bp next result", res, 32'd2);
    checkOutput("bp next latency", 32'(lat), 32'(expLatency));

    // Reset in the middle of CALC, asserted and released between edges.
    @(negedge clk);
    v_i              = 1'b1;
    dividend_i       = 32'd5000;
    divisor_i        = 32'd3;
    signed_i         = 1'b0;
    gets_remainder_i = 1'b0;
    @(posedge clk);
    #1;
    v_i = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    reset_n_i = 1'b0;
    #1;
    checkOutput("midcalc reset ready", {31'b0, ready_and_o}, 32'd1);
    checkOutput("midcalc reset v_o", {31'b0, v_o}, 32'd0);
    checkOutput("midcalc reset result", result_o, 32'd0);
    #2;
    reset_n_i = 1'b1;
    applyStimulus(32'd1000, 32'd10, 1'b0, 1'b0, 1'b1, res, lat);
    checkOutput("post reset 1000/10", res, 32'd100);
    checkOutput("post reset latency", 32'(lat), 32'(expLatency));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
